modfrac_unit: RTL and testbench

MODFRAC_UNIT -- requirements
Module: modfrac_unit

---
 rtl/modfrac_unit.sv | 151 +++++++++++++++
 tb/tb_modfrac_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/modfrac_unit.sv
// Modular fraction unit: result = num * den^-1 mod Q using a sequential
// extended Euclid (restoring divider per step) followed by a shift-subtract reduction.
module modfrac_unit #(
  parameter int W = 13,
  parameter int Q = 4591
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err,
  output logic [2:0]   dbg_state
);

  localparam logic [W-1:0] QW = W'(Q);
  localparam int CW = $clog2(2 * W + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIV  = 3'd1,
    S_UPD  = 3'd2,
    S_MUL  = 3'd3,
    S_RED  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  // Handshake: start is sampled only while IDLE; busy rises the cycle after
  // acceptance and falls together with the single-cycle done pulse.

  state_t state, state_nx;

  logic [W-1:0]        r0, r1, num_q;
  logic signed [W:0]   t0, t1;
  logic [W:0]          acc;
  logic [2*W-1:0]      sh;
  logic [CW-1:0]       cnt;
  logic                err_pend;

  logic                div_mode, shift_bit, fits;
  logic [W:0]          divisor, rem_sh, rem_nx;
  logic [W-1:0]        qd;
  logic signed [2*W+1:0] prod;
  logic signed [W:0]   t1_nx, inv_s;
  logic [2*W-1:0]      p;

  assign dbg_state = state;

  // Shared shift-subtract step: divides r0 by r1 in DIV, reduces p by Q in RED.
  always_comb begin
    div_mode  = (state == S_DIV);
    shift_bit = div_mode ? sh[W-1] : sh[2*W-1];
    divisor   = div_mode ? {1'b0, r1} : {1'b0, QW};
    rem_sh    = {acc[W-1:0], shift_bit};
    fits      = (rem_sh >= divisor);
    rem_nx    = fits ? (rem_sh - divisor) : rem_sh;
    qd        = sh[W-1:0];
    prod      = $signed({1'b0, qd}) * t1;
    t1_nx     = t0 - $signed(prod[W:0]);
    inv_s     = t0[W] ? (t0 + $signed({1'b0, QW})) : t0;
    p         = {{W{1'b0}}, num_q} * {{W{1'b0}}, inv_s[W-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = (den != '0) ? S_DIV : S_FIN;
      S_DIV:  if (cnt == CW'(W - 1)) state_nx = S_UPD;
      S_UPD: begin
        if (acc[W-1:0] != '0)    state_nx = S_DIV;
        else if (r1 == W'(1))    state_nx = S_MUL;
        else                     state_nx = S_FIN;
      end
      S_MUL:  state_nx = S_RED;
      S_RED:  if (cnt == CW'(2 * W - 1)) state_nx = S_FIN;
      S_FIN:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0       <= '0;
      r1       <= '0;
      num_q    <= '0;
      t0       <= '0;
      t1       <= '0;
      acc      <= '0;
      sh       <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          num_q    <= num;
          r0       <= QW;
          r1       <= den;
          t0       <= '0;
          t1       <= (W+1)'(1);
          acc      <= '0;
          sh       <= {{W{1'b0}}, QW};
          cnt      <= '0;
          busy     <= 1'b1;
          err_pend <= (den == '0);
        end
        S_DIV, S_RED: begin
          acc <= rem_nx;
          sh  <= {sh[2*W-2:0], fits};
          cnt <= cnt + CW'(1);
        end
        S_UPD: begin
          // acc holds the remainder and sh the quotient of the step just finished.
          r0  <= r1;
          r1  <= acc[W-1:0];
          t0  <= t1;
          t1  <= t1_nx;
          acc <= '0;
          sh  <= {{W{1'b0}}, r1};
          cnt <= '0;
          if ((acc[W-1:0] == '0) && (r1 != W'(1))) err_pend <= 1'b1;
        end
        S_MUL: begin
          sh  <= p;
          acc <= '0;
          cnt <= '0;
        end
        S_FIN: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          err    <= err_pend;
          result <= err_pend ? '0 : acc[W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modfrac_unit.sv
// Bench for modfrac_unit: directed operations checked against an arithmetic
// model (Fermat inverse, Euclid step count) plus literal pins.
module tb_modfrac_unit;
  localparam int W = 13;
  localparam int Q = 4591;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] num = '0;
  logic [W-1:0] den = '0;
  logic         busy, done, err;
  logic [W-1:0] result;
  logic [2:0]   dbg_state;

  modfrac_unit #(.W(W), .Q(Q)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num(num), .den(den),
    .busy(busy), .done(done), .result(result), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];
  int           exp_lat_q[$];
  int           exp_st_q[$];
  int           exp_num_q[$];
  int           exp_den_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural model
  function automatic longint modpow(input longint b, input longint e);
    longint r = 1;
    b = b % Q;
    while (e > 0) begin
      if (e % 2 == 1) r = (r * b) % Q;
      b = (b * b) % Q;
      e = e / 2;
    end
    return r;
  endfunction

  function automatic int model_res(input int n, input int d);
    if (d % Q == 0) return 0;
    return int'((longint'(n % Q) * modpow(d, Q - 2)) % Q);
  endfunction

  function automatic int model_steps(input int d);
    int a = Q;
    int b = d;
    int k = 0;
    int t;
    while (b != 0) begin
      t = a % b; a = b; b = t; k++;
    end
    return k;
  endfunction

  function automatic int model_lat(input int d);
    int k = model_steps(d);
    if (d % Q == 0) return k * (W + 1) + 2;
    return k * (W + 1) + 2 * W + 3;
  endfunction

  // scoreboard / compare process
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0)
        check("busy", busy, (cyc > exp_st_q[0]) && (cyc < exp_st_q[0] + exp_lat_q[0]));
      else
        check("busy_idle", busy, 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          automatic logic [W-1:0] er = exp_q.pop_front();
          automatic logic ee = exp_err_q.pop_front();
          automatic int el = exp_lat_q.pop_front();
          automatic int es = exp_st_q.pop_front();
          automatic int en = exp_num_q.pop_front();
          automatic int ed = exp_den_q.pop_front();
          check("result", result, er);
          check("err", err, ee);
          check("latency", cyc - es, el);
          check("latency_bound", (cyc - es) <= (W + 1) * (2 * W) + 2 * W + 3, 1);
          if (!ee) check("result_times_den", (longint'(result) * ed) % Q, en % Q);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_idle();
    int b = 0;
    while ((busy || exp_q.size() != 0) && b < 2000) begin
      @(posedge clk); #1; b++;
    end
    if (b >= 2000) check("idle_timeout", 1, 0);
  endtask

  task automatic push_exp(input int n, input int d, input int er, input bit ee, input int el);
    exp_q.push_back(W'(er));
    exp_err_q.push_back(ee);
    exp_lat_q.push_back(el);
    exp_st_q.push_back(cyc);
    exp_num_q.push_back(n);
    exp_den_q.push_back(d);
  endtask

  task automatic issue(input int n, input int d, input int er, input bit ee, input int el);
    wait_idle();
    num = W'(n); den = W'(d); start = 1'b1;
    push_exp(n, d, er, ee, el);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic issue_model(input int n, input int d);
    issue(n, d, model_res(n, d), (d % Q) == 0, model_lat(d));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  int vec_n[10] = '{8191, 3, 4590, 100, 8191, 0, 1234, 4590, 17, 4592};
  int vec_d[10] = '{8191, 4592, 4590, 8190, 1, 5, 4321, 3, 4589, 7};

  initial begin
    // model pins (hand-computed)
    check("pin_model_1_2", model_res(1, 2), 2296);
    check("pin_model_1_4590", model_res(1, 4590), 4590);
    check("pin_model_lat_2", model_lat(2), 57);
    check("pin_model_lat_q", model_lat(Q), 16);

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed literal expectations
    issue(1, 2, 2296, 0, 57);
    issue(1, 4590, 4590, 0, 57);
    issue(4591, 1, 0, 0, 43);
    issue(5, 0, 0, 1, 2);
    issue(7, 4591, 0, 1, 16);
    issue(3, 1, 3, 0, 43);

    // directed vectors against the model
    for (int i = 0; i < 10; i++) issue_model(vec_n[i], vec_d[i]);
    for (int i = 0; i < 30; i++)
      issue_model(int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)));

    // start held high through a whole operation: one accept, then back-to-back at done
    wait_idle();
    begin
      automatic int l = model_lat(3);
      num = W'(25); den = W'(3); start = 1'b1;
      push_exp(25, 3, model_res(25, 3), 0, l);
      repeat (l) @(posedge clk);
      #1;
      push_exp(25, 3, model_res(25, 3), 0, l);
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_idle();

    // asynchronous reset during DIV
    issue(1, 2, 2296, 0, 57);
    issue_model(9, 1234);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    exp_q.delete(); exp_err_q.delete(); exp_lat_q.delete();
    exp_st_q.delete(); exp_num_q.delete(); exp_den_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue(1, 2, 2296, 0, 57);
    issue(1, 4590, 4590, 0, 57);
    wait_idle();

    check("pending_at_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
